// File: rtl/regfile_reader_11b_pkg.sv
// Shared definitions for the 11-bit register-bank read controller.
// Holds the word width, the controller state encoding and the flattened-bus slice helper.
package regfile_reader_11b_pkg;

    localparam int DATA_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        VALID  = 2'd2
    } state_t;

    // LSB position of register idx inside a flattened NREGS*DATA_W bus
    function automatic int unsigned word_lsb(input int unsigned idx);
        return idx * DATA_W;
    endfunction

endpackage

// File: rtl/regfile_reader_11b_onehot_dec.sv
// Binary-to-one-hot decoder with an enable; all outputs are zero while disabled.
// Shared by the read-side controller and the planned write-side controller.
module onehot_dec #(
    parameter int N  = 8,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [AW-1:0] idx,
    input  logic          en,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_reader_11b.sv
// Read-side controller for a bank of 11-bit registers: selects one register per word,
// captures its data/err pair and hands it downstream over a valid/ready handshake.
module regfile_reader_11b
    import regfile_reader_11b_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [AW-1:0]           rd_addr,
    input  logic [AW:0]             rd_len,
    output logic [NREGS-1:0]        sel,
    input  logic [NREGS*DATA_W-1:0] bank_data,
    input  logic [NREGS-1:0]        bank_err,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_werr,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    busy,
    output logic                    req_err
);

    localparam logic [AW:0]   NREGS_L = (AW + 1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t      state;
    state_t      next_state;
    logic [AW-1:0] cur;
    logic [AW:0]   rem;
    logic          req_legal;

    assign req_legal = (rd_len != '0) && (rd_len <= NREGS_L) && ({1'b0, rd_addr} < NREGS_L);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rd_req && req_legal) begin
                    next_state = SELECT;
                end
            end
            SELECT: next_state = VALID;
            VALID: begin
                if (rd_ready) begin
                    next_state = (rem == (AW + 1)'(1)) ? IDLE : SELECT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture happens on the edge that leaves SELECT, so data is held for the whole VALID phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cur     <= '0;
            rem     <= '0;
            rd_data <= '0;
            rd_werr <= 1'b0;
            req_err <= 1'b0;
        end else begin
            state   <= next_state;
            req_err <= (state == IDLE) && rd_req && !req_legal;
            case (state)
                IDLE: begin
                    if (rd_req && req_legal) begin
                        cur <= rd_addr;
                        rem <= rd_len;
                    end
                end
                SELECT: begin
                    rd_data <= bank_data[word_lsb(32'(cur)) +: DATA_W];
                    rd_werr <= bank_err[cur];
                end
                VALID: begin
                    if (rd_ready && (rem != (AW + 1)'(1))) begin
                        rem <= rem - 1'b1;
                        cur <= (cur == LAST_IDX) ? '0 : cur + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign rd_valid = (state == VALID);

    onehot_dec #(
        .N  (NREGS),
        .AW (AW)
    ) u_sel_dec (
        .idx    (cur),
        .en     (state == SELECT),
        .onehot (sel)
    );

endmodule

// File: tb/tb_regfile_reader_11b.sv
// Directed self-checking bench for regfile_reader_11b with an 8-register bank model.
module tb_regfile_reader_11b;

    localparam int NREGS = 8;
    localparam int AW    = 3;
    localparam int DW    = 11;

    logic                 clk;
    logic                 rst;
    logic                 rd_req;
    logic [AW-1:0]        rd_addr;
    logic [AW:0]          rd_len;
    logic [NREGS-1:0]     sel;
    logic [NREGS*DW-1:0]  bank_data;
    logic [NREGS-1:0]     bank_err;
    logic [DW-1:0]        rd_data;
    logic                 rd_werr;
    logic                 rd_valid;
    logic                 rd_ready;
    logic                 busy;
    logic                 req_err;

    logic [DW-1:0] regs [NREGS];

    int vectors;
    int miscompares;

    regfile_reader_11b #(
        .NREGS (NREGS),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .sel       (sel),
        .bank_data (bank_data),
        .bank_err  (bank_err),
        .rd_data   (rd_data),
        .rd_werr   (rd_werr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .req_err   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bank_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            bank_data[i*DW +: DW] = regs[i];
        end
    end

    // Runs one burst and checks every word against the bank model; optionally pokes rd_req while busy
    task automatic run_burst(input int addr, input int len, input int seed, input bit poke_req);
        logic [DW-1:0]    exp_data;
        logic             exp_err;
        logic [NREGS-1:0] exp_sel;
        int idx;
        int stall;
        int waited;
        rd_req  = 1'b1;
        rd_addr = AW'(addr);
        rd_len  = (AW + 1)'(len);
        @(posedge clk);
        #1 rd_req = 1'b0;
        for (int w = 0; w < len; w++) begin
            idx      = (addr + w) % NREGS;
            exp_data = regs[idx];
            exp_err  = bank_err[idx];
            exp_sel  = '0;
            exp_sel[idx] = 1'b1;
            waited = 0;
            @(negedge clk);
            while (sel == '0 && waited < 8) begin
                waited++;
                @(negedge clk);
            end
            vectors++;
            if (sel !== exp_sel || rd_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL burst_sel word %0d: sel=%b valid=%b busy=%b, required sel=%b valid=0 busy=1",
                         w, sel, rd_valid, busy, exp_sel);
                return;
            end
            @(negedge clk);
            vectors++;
            if (sel !== '0 || rd_valid !== 1'b1 || rd_data !== exp_data || rd_werr !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL burst_word %0d: sel=%b valid=%b data=%h werr=%b, required sel=0 valid=1 data=%h werr=%b",
                         w, sel, rd_valid, rd_data, rd_werr, exp_data, exp_err);
            end
            if (poke_req && w == 0) begin
                rd_req  = 1'b1;
                rd_addr = 3'd2;
                rd_len  = 4'd1;
            end
            stall = (w * 3 + seed) % 6;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== exp_data || rd_werr !== exp_err || sel !== '0 || req_err !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL stall_stable word %0d cycle %0d: valid=%b data=%h werr=%b sel=%b req_err=%b, required valid=1 data=%h werr=%b sel=0 req_err=0",
                             w, s, rd_valid, rd_data, rd_werr, sel, req_err, exp_data, exp_err);
                end
            end
            rd_ready = 1'b1;
            @(posedge clk);
            #1 rd_ready = 1'b0;
            rd_req = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || sel !== '0 || req_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL burst_end: busy=%b valid=%b sel=%b req_err=%b, required all 0",
                     busy, rd_valid, sel, req_err);
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || sel !== '0 || rd_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL no_extra_word: busy=%b sel=%b valid=%b, required all 0", busy, sel, rd_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        rd_len   = '0;
        rd_ready = 1'b0;
        bank_err = '0;
        regs[0] = 11'h011; regs[1] = 11'h122; regs[2] = 11'h233; regs[3] = 11'h344;
        regs[4] = 11'h455; regs[5] = 11'h2A5; regs[6] = 11'h677; regs[7] = 11'h7FE;
        repeat (2) @(negedge clk);
        vectors++;
        if (sel !== '0 || rd_data !== '0 || rd_werr !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0 || req_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: sel=%b data=%h werr=%b valid=%b busy=%b req_err=%b, required all 0",
                     sel, rd_data, rd_werr, rd_valid, busy, req_err);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        rd_req  = 1'b1;
        rd_addr = 3'd5;
        rd_len  = 4'd1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (sel !== 8'b0010_0000 || busy !== 1'b1 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_select: sel=%b busy=%b valid=%b, required sel=00100000 busy=1 valid=0", sel, busy, rd_valid);
        end
        @(negedge clk);
        vectors++;
        if (sel !== '0 || rd_valid !== 1'b1 || rd_data !== 11'h2A5 || rd_werr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_valid: sel=%b valid=%b data=%h werr=%b, required sel=0 valid=1 data=2a5 werr=0",
                     sel, rd_valid, rd_data, rd_werr);
        end
        rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || sel !== '0) begin
            miscompares++;
            $display("[TB] FAIL single_done: busy=%b valid=%b sel=%b, required all 0", busy, rd_valid, sel);
        end
    endtask

    task automatic test_wrap_burst();
        run_burst(6, 4, 2, 1'b0);
    endtask

    task automatic test_full_bank();
        run_burst(3, 8, 1, 1'b0);
    endtask

    task automatic test_illegal();
        logic [AW:0] bad_len [2];
        bad_len[0] = 4'd0;
        bad_len[1] = 4'd9;
        for (int i = 0; i < 2; i++) begin
            rd_req  = 1'b1;
            rd_addr = 3'd1;
            rd_len  = bad_len[i];
            @(posedge clk);
            #1 rd_req = 1'b0;
            @(negedge clk);
            vectors++;
            if (req_err !== 1'b1 || busy !== 1'b0 || sel !== '0 || rd_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL illegal_pulse len=%0d: req_err=%b busy=%b sel=%b valid=%b, required req_err=1 others 0",
                         bad_len[i], req_err, busy, sel, rd_valid);
            end
            @(negedge clk);
            vectors++;
            if (req_err !== 1'b0 || busy !== 1'b0 || sel !== '0 || rd_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL illegal_after len=%0d: req_err=%b busy=%b sel=%b valid=%b, required all 0",
                         bad_len[i], req_err, busy, sel, rd_valid);
            end
        end
    endtask

    task automatic test_busy_ignore();
        run_burst(4, 3, 4, 1'b1);
    endtask

    task automatic test_err_propagation();
        bank_err = 8'b0000_1000;
        run_burst(2, 3, 0, 1'b0);
        bank_err = '0;
    endtask

    task automatic test_reset_mid_burst();
        rd_req  = 1'b1;
        rd_addr = 3'd0;
        rd_len  = 4'd4;
        @(posedge clk);
        #1 rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 11'h122) begin
            miscompares++;
            $display("[TB] FAIL mid_burst_word2: valid=%b data=%h, required valid=1 data=122", rd_valid, rd_data);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (sel !== '0 || rd_data !== '0 || rd_werr !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0 || req_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: sel=%b data=%h werr=%b valid=%b busy=%b req_err=%b, required all 0",
                     sel, rd_data, rd_werr, rd_valid, busy, req_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || rd_valid !== 1'b0 || sel !== '0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle: busy=%b valid=%b sel=%b, required all 0", busy, rd_valid, sel);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_read();
        test_wrap_burst();
        test_illegal();
        test_busy_ignore();
        test_err_propagation();
        test_full_bank();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_reader_11b.md
# regfile_reader_11b

Read-side controller for a bank of `register_11b`-style 11-bit registers. It accepts a read request for one register or a burst of consecutive registers, and drives the one-hot `chosen` select lines of the bank. It captures the selected `r_data`/`err` pair and presents each word to a downstream consumer through a valid/ready handshake. It sits between the register bank and the datapath or debug port that consumes register contents.

## Interface
- `NREGS`, default 8: number of registers in the bank (2..16).
- `AW`, default 3: address width, equal to clog2(NREGS).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `rd_req`  in  1  request strobe; sampled only while `busy`=0.
- `rd_addr`  in  AW  first register index of the read.
- `rd_len`  in  AW+1  number of words to read; legal range is 1..NREGS.
- `sel`  out  NREGS  one-hot `chosen` lines to the bank.
- `bank_data`  in  NREGS*11  flattened `r_data` of all registers; register i occupies bits [11i+10:11i].
- `bank_err`  in  NREGS  `err` outputs of the registers.
- `rd_data`  out  11  captured word.
- `rd_werr`  out  1  captured `err` bit of the word on `rd_data`.
- `rd_valid`  out  1  `rd_data`/`rd_werr` are valid.
- `rd_ready`  in  1  consumer accepts the word.
- `busy`  out  1  a burst is in progress.
- `req_err`  out  1  one-cycle pulse when a request is illegal.

## Operation
- The FSM has three states: IDLE, SELECT, VALID.
- IDLE:
  - If `rd_req`=1 and `rd_len` is in 1..NREGS and `rd_addr`<NREGS: latch the address into `cur`, latch the length into `rem`, and go to SELECT.
  - If `rd_req`=1 and the request is illegal (`rd_len`=0, `rd_len`>NREGS, or `rd_addr`≥NREGS): pulse `req_err` for one cycle and stay in IDLE.
- SELECT:
  - `sel` = one-hot(`cur`); every other bit of `sel` is 0.
  - At the clock edge, `rd_data` takes `bank_data[cur]` and `rd_werr` takes `bank_err[cur]`. Go to VALID.
- VALID:
  - `rd_valid`=1 and `sel`=0.
  - `rd_data` and `rd_werr` stay stable until the handshake completes.
  - A handshake occurs when `rd_ready`=1. On a handshake:
    - If `rem`=1, go to IDLE.
    - Otherwise `rem`←`rem`−1, `cur`←(`cur`+1) mod NREGS, and go to SELECT.
- Address wrap: `cur` goes from NREGS−1 back to 0. A burst of NREGS words therefore reads every register exactly once.
- `busy`=1 in SELECT and in VALID. `rd_req` is ignored while `busy`=1; it does not queue and does not raise `req_err`.
- The block never asserts `w_en` or writes to the bank; the bank is read-only from this block.
- Reset, including mid-burst: state returns to IDLE. All outputs go to 0: `sel`, `rd_data`, `rd_werr`, `rd_valid`, `busy`, `req_err`. `cur` and `rem` also clear to 0.

## Timing
- A request sampled at edge k gives SELECT during cycle k+1 and `rd_valid`=1 from edge k+2.
- Minimum per-word period is 2 cycles (SELECT then VALID with `rd_ready`=1). Back-to-back words are therefore never on consecutive cycles.
- `rd_valid` may stay high for any number of cycles while `rd_ready`=0; data must not change during that time.
- Handshake on the final word at edge m: `busy`=0 from edge m, and a new request can be sampled at edge m+1.
- `req_err` is high for exactly the cycle after the edge at which the illegal request was sampled.
- `sel` is driven from registered state: a pure decode of the registered `cur` and state, with no combinational path from any input.

## Structure
- Shared package / `define header holds:
  - DATA_W=11;
  - the state encoding (IDLE=2'd0, SELECT=2'd1, VALID=2'd2);
  - the flattened-bus slice macro for index i.
- Sub-module `onehot_dec` (parameter N): binary `cur` in, N-bit one-hot out, and an enable input gated by SELECT. It is reused by a future write-side controller.
- All flops use the codebase `dff` cell or an equivalent async-low-reset always block. Do not use a synchronous-reset style.

## Test plan
- Reset then single read: preload reg 5 with 11'h2A5, then `rd_req`, `rd_addr`=5, `rd_len`=1. Expect `sel`=8'b0010_0000 for exactly one cycle, then `rd_valid` with `rd_data`=11'h2A5, then `busy`=0 after `rd_ready`.
- Wrapping burst: `rd_addr`=6, `rd_len`=4. Expect words from regs 6, 7, 0, 1 in that order, each with one `sel` pulse. Apply `rd_ready` with random stalls of 0–5 cycles; `rd_data` must stay stable during every stall.
- Illegal requests: `rd_len`=0, then `rd_len`=9. Expect a one-cycle `req_err` for each, with `busy`, `sel` and `rd_valid` all staying 0.
- Busy ignore: during a 3-word burst, pulse `rd_req` with `rd_addr`=2. Expect the burst to complete unaltered, with no extra words and no `req_err`.
- Error propagation: force `bank_err[3]`=1 and read regs 2..4. Expect `rd_werr` = 0, 1, 0 on the three words.
- Reset mid-burst: assert `rst`=0 while in VALID of word 2 of 4. Expect all outputs 0 immediately (asynchronously). After release, expect IDLE with no residual `rd_valid`.
